// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: sequential word fetches over a req/ack
// handshake, buffered with their PCs in a DEPTH-entry FIFO. An execute-stage
// redirect flushes the FIFO and restarts fetching at the new target.
// Optional build macro FETCH_Q_BYPASS_EN: an ack arriving into an empty FIFO
// drives instr/instr_pc combinationally in the same cycle.
module fetch_prefetch_queue #(
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    redirect,
  input  logic [XLEN-1:0]         redirect_pc,
  input  logic                    fetch_ready,
  output logic                    instr_valid,
  output logic [XLEN-1:0]         instr,
  output logic [XLEN-1:0]         instr_pc,
  output logic                    imem_req,
  output logic [XLEN-1:0]         imem_addr,
  input  logic                    imem_ack,
  input  logic [XLEN-1:0]         imem_rdata,
  output logic [$clog2(DEPTH):0]  occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  typedef struct packed {
    logic [XLEN-1:0] word;
    logic [XLEN-1:0] pc;
  } entry_t;

  state_t          state, state_d;
  logic            req_d;
  logic [XLEN-1:0] addr_d;
  logic [XLEN-1:0] fetch_pc, fetch_pc_d;
  logic [XLEN-1:0] target;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count, occ_after;
  logic            fifo_empty;
  logic            push, pop;
  logic            bypass, byp_take;
  logic            unused_pc_bits;

  // Low two bits of the redirect target are ignored (word-aligned fetch).
  assign unused_pc_bits = ^redirect_pc[1:0];
  assign target         = {redirect_pc[XLEN-1:2], 2'b00};
  assign fifo_empty     = (count == '0);
  assign occupancy      = count;
  assign pop            = !fifo_empty && fetch_ready && !redirect;
  assign byp_take       = bypass && fetch_ready;

  // Bypass qualifier: live ack into an empty FIFO, never in DROP or on redirect.
  always_comb begin
    bypass = 1'b0;
`ifdef FETCH_Q_BYPASS_EN
    bypass = (state == S_WAIT) && imem_ack && !redirect && fifo_empty;
`endif
  end

  // Head presentation: bypassed word, else FIFO head, else NOP.
  always_comb begin
    instr_valid = 1'b0;
    instr       = NOP;
    instr_pc    = '0;
    if (bypass) begin
      instr_valid = 1'b1;
      instr       = imem_rdata;
      instr_pc    = imem_addr;
    end else if (!fifo_empty) begin
      instr_valid = 1'b1;
      instr       = mem[rd_ptr].word;
      instr_pc    = mem[rd_ptr].pc;
    end
  end

  // Next-state and request logic; a request is only issued if its ack has a slot.
  always_comb begin
    state_d    = state;
    req_d      = imem_req;
    addr_d     = imem_addr;
    fetch_pc_d = fetch_pc;
    push       = 1'b0;
    occ_after  = count;
    case (state)
      S_IDLE: begin
        if (redirect) begin
          fetch_pc_d = target;
        end else if (count < CW'(DEPTH)) begin
          req_d   = 1'b1;
          addr_d  = fetch_pc;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          fetch_pc_d = target;
          if (imem_ack) begin
            req_d   = 1'b0;
            state_d = S_IDLE;
          end else begin
            state_d = S_DROP;
          end
        end else if (imem_ack) begin
          push       = !byp_take;
          fetch_pc_d = fetch_pc + XLEN'(4);
          occ_after  = count + CW'(push) - CW'(pop);
          if (occ_after < CW'(DEPTH)) begin
            addr_d = fetch_pc + XLEN'(4);
          end else begin
            req_d   = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      S_DROP: begin
        if (redirect) begin
          fetch_pc_d = target;
        end
        if (imem_ack) begin
          req_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // FSM state, request and fetch-PC registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      fetch_pc  <= RESET_PC;
    end else begin
      state     <= state_d;
      imem_req  <= req_d;
      imem_addr <= addr_d;
      fetch_pc  <= fetch_pc_d;
    end
  end

  // FIFO pointers and count; redirect clears and voids any push/pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage (no reset needed; validity tracked by count).
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{word: imem_rdata, pc: imem_addr};
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: directed scenarios plus randomized traffic
// checked against a transaction-level queue model.
module tb_fetch_prefetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NOP_W = 32'h0000_0013;
`ifdef FETCH_Q_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        fetch_ready = 1'b0;
  logic        instr_valid;
  logic [31:0] instr, instr_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic [2:0]  occupancy;

  int n_cmp = 0;
  int n_bad = 0;
  int n_pops = 0;

  fetch_prefetch_queue #(.DEPTH(DEPTH), .XLEN(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .fetch_ready(fetch_ready), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h0050_00B3;
  endfunction

  always_comb imem_rdata = mem_word(imem_addr);

  // Reference model: expected fetch stream as a queue of {word, pc}.
  typedef struct {
    logic [31:0] w;
    logic [31:0] pc;
  } ent_t;

  ent_t        q[$];
  logic [31:0] next_fetch = '0;
  bit          out_active = 1'b0;
  bit          out_drop = 1'b0;
  logic [31:0] out_addr = '0;
  bit          ack_evt, byp_evt, exp_valid;
  ent_t        exp_e;

  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      next_fetch = '0;
      out_active = 1'b0;
      out_drop   = 1'b0;
    end else begin
      ack_evt = (imem_req === 1'b1) && imem_ack;
      if (imem_req === 1'b1 && !out_active) begin
        n_cmp++;
        if (imem_addr !== next_fetch) begin
          n_bad++;
          $display("FAIL req_addr: got %h expected %h", imem_addr, next_fetch);
        end
        out_active = 1'b1;
        out_drop   = 1'b0;
        out_addr   = imem_addr;
      end else if (out_active) begin
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== out_addr) begin
          n_bad++;
          $display("FAIL req_hold: got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, out_addr);
        end
      end
      byp_evt   = BYP && (q.size() == 0) && ack_evt && !out_drop && !redirect;
      exp_valid = (q.size() != 0) || byp_evt;
      if (q.size() != 0) exp_e = q[0];
      else if (byp_evt)  exp_e = '{w: mem_word(imem_addr), pc: imem_addr};
      else               exp_e = '{w: NOP_W, pc: 32'h0};
      n_cmp++;
      if (instr_valid !== exp_valid || instr !== exp_e.w || instr_pc !== exp_e.pc) begin
        n_bad++;
        $display("FAIL head: got v=%b instr=%h pc=%h expected v=%b instr=%h pc=%h",
                 instr_valid, instr, instr_pc, exp_valid, exp_e.w, exp_e.pc);
      end
      n_cmp++;
      if (occupancy !== 3'(q.size())) begin
        n_bad++;
        $display("FAIL occupancy: got %0d expected %0d", occupancy, q.size());
      end
      n_cmp++;
      if (q.size() + ((out_active && !out_drop) ? 1 : 0) > DEPTH) begin
        n_bad++;
        $display("FAIL slot_reserve: got %0d in flight expected <= %0d", q.size() + 1, DEPTH);
      end
      if (redirect) begin
        q.delete();
        next_fetch = {redirect_pc[31:2], 2'b00};
        if (out_active) out_drop = 1'b1;
      end
      if (ack_evt && out_active) begin
        if (!out_drop) begin
          q.push_back('{w: mem_word(out_addr), pc: out_addr});
          next_fetch = next_fetch + 32'd4;
        end
        out_active = 1'b0;
      end
      if (exp_valid && fetch_ready && !redirect && q.size() != 0) begin
        void'(q.pop_front());
        n_pops++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; redirect = 1'b0; imem_ack = 1'b0; fetch_ready = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  // Async reset taken mid-transaction returns every output at once.
  task automatic test_reset();
    do_reset();
    repeat (3) tick();
    reset = 1'b1;
    #1;
    n_cmp++;
    if (instr_valid !== 1'b0 || instr !== NOP_W || instr_pc !== 32'h0 ||
        imem_req !== 1'b0 || imem_addr !== 32'h0 || occupancy !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_values: got v=%b instr=%h pc=%h req=%b addr=%h occ=%0d expected 0 13 0 0 0 0",
               instr_valid, instr, instr_pc, imem_req, imem_addr, occupancy);
    end
    tick();
    reset = 1'b0;
  endtask

  // Zero-wait memory, always-ready consumer: back-to-back addresses.
  task automatic test_stream();
    int k;
    bit prev_req;
    logic [31:0] prev_addr;
    do_reset();
    imem_ack = 1'b1; fetch_ready = 1'b1;
    k = 0; prev_req = 1'b0; prev_addr = '0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (!BYP && prev_req) begin
        n_cmp++;
        if (instr_valid !== 1'b1 || instr_pc !== prev_addr) begin
          n_bad++;
          $display("FAIL stream_pc_lag: got v=%b pc=%h expected v=1 pc=%h", instr_valid, instr_pc, prev_addr);
        end
      end
      if (imem_req && k < 4) begin
        n_cmp++;
        if (imem_addr !== 32'(4 * k)) begin
          n_bad++;
          $display("FAIL stream_addr: got %h expected %h", imem_addr, 32'(4 * k));
        end
        k++;
      end
      n_cmp++;
      if (occupancy > 3'd1) begin
        n_bad++;
        $display("FAIL stream_occ: got %0d expected <= 1", occupancy);
      end
      prev_req = imem_req;
      prev_addr = imem_addr;
    end
    n_cmp++;
    if (k != 4) begin
      n_bad++;
      $display("FAIL stream_count: got %0d expected 4", k);
    end
  endtask

  // Stalled consumer fills the FIFO, then drains in order.
  task automatic test_fill();
    int nreq, j;
    do_reset();
    imem_ack = 1'b1; fetch_ready = 1'b0;
    nreq = 0;
    repeat (10) begin
      @(negedge clk);
      if (imem_req) nreq++;
    end
    n_cmp++;
    if (nreq != 4 || occupancy !== 3'd4 || imem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL fill: got reqs=%0d occ=%0d req=%b expected 4 4 0", nreq, occupancy, imem_req);
    end
    tick();
    fetch_ready = 1'b1;
    j = 0;
    for (int c = 0; c < 20 && j < 4; c++) begin
      @(negedge clk);
      if (instr_valid && fetch_ready) begin
        n_cmp++;
        if (instr_pc !== 32'(4 * j) || instr !== mem_word(32'(4 * j))) begin
          n_bad++;
          $display("FAIL drain_order: got pc=%h instr=%h expected pc=%h", instr_pc, instr, 32'(4 * j));
        end
        j++;
      end
    end
    n_cmp++;
    if (j != 4) begin
      n_bad++;
      $display("FAIL drain_count: got %0d expected 4", j);
    end
  endtask

  // Redirect with three entries and a request outstanding.
  task automatic test_redirect_flush();
    bit hit;
    do_reset();
    imem_ack = 1'b1; fetch_ready = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      tick();
      if (occupancy == 3'd3) hit = 1'b1;
    end
    n_cmp++;
    if (!hit) begin
      n_bad++;
      $display("FAIL flush_setup: got occ=%0d expected 3", occupancy);
    end
    imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    n_cmp++;
    if (occupancy !== 3'd0 || instr_valid !== 1'b0 || imem_req !== 1'b1) begin
      n_bad++;
      $display("FAIL flush: got occ=%0d v=%b req=%b expected 0 0 1", occupancy, instr_valid, imem_req);
    end
    tick();
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 6 && !hit; c++) begin
      tick();
      if (imem_req) hit = 1'b1;
    end
    n_cmp++;
    if (!hit || imem_addr !== 32'h0000_0100) begin
      n_bad++;
      $display("FAIL flush_target: got req=%b addr=%h expected 1 00000100", imem_req, imem_addr);
    end
    imem_ack = 1'b1; fetch_ready = 1'b1;
    repeat (4) tick();
  endtask

  // Redirect while a slow request is outstanding: its word must vanish.
  task automatic test_drop();
    bit hit, seen_req, seen_pop, bad10;
    do_reset();
    imem_ack = 1'b1; fetch_ready = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      tick();
      if (imem_req && imem_addr == 32'h10) hit = 1'b1;
    end
    imem_ack = 1'b0;
    tick();
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    n_cmp++;
    if (!hit || imem_req !== 1'b1 || imem_addr !== 32'h10 || occupancy !== 3'd0) begin
      n_bad++;
      $display("FAIL drop_hold: got req=%b addr=%h occ=%0d expected 1 00000010 0", imem_req, imem_addr, occupancy);
    end
    tick();
    imem_ack = 1'b1;
    seen_req = 1'b0; seen_pop = 1'b0; bad10 = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!seen_req && imem_req && imem_addr !== 32'h10) begin
        n_cmp++;
        if (imem_addr !== 32'h40) begin
          n_bad++;
          $display("FAIL drop_next_req: got %h expected 00000040", imem_addr);
        end
        seen_req = 1'b1;
      end
      if (instr_valid && fetch_ready) begin
        if (!seen_pop) begin
          n_cmp++;
          if (instr_pc !== 32'h40) begin
            n_bad++;
            $display("FAIL drop_first_pop: got %h expected 00000040", instr_pc);
          end
        end
        seen_pop = 1'b1;
        if (instr_pc == 32'h10) bad10 = 1'b1;
      end
    end
    n_cmp++;
    if (!seen_req || !seen_pop || bad10) begin
      n_bad++;
      $display("FAIL drop_stream: got req=%b pop=%b saw10=%b expected 1 1 0", seen_req, seen_pop, bad10);
    end
  endtask

  // Redirect coinciding with an ack: data discarded, FSM idles.
  task automatic test_redirect_ack_same();
    bit hit;
    do_reset();
    imem_ack = 1'b1; fetch_ready = 1'b1;
    repeat (5) tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0202;
    tick();
    redirect = 1'b0;
    n_cmp++;
    if (imem_req !== 1'b0 || occupancy !== 3'd0 || instr_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL same_cycle: got req=%b occ=%0d v=%b expected 0 0 0", imem_req, occupancy, instr_valid);
    end
    hit = 1'b0;
    for (int c = 0; c < 6 && !hit; c++) begin
      tick();
      if (imem_req) hit = 1'b1;
    end
    n_cmp++;
    if (!hit || imem_addr !== 32'h0000_0200) begin
      n_bad++;
      $display("FAIL same_cycle_target: got req=%b addr=%h expected 1 00000200", imem_req, imem_addr);
    end
  endtask

  // Fetch PC wraps from the top of the address space to zero.
  task automatic test_wrap();
    logic [31:0] exp_pc [4];
    int j;
    exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0; exp_pc[3] = 32'h4;
    do_reset();
    imem_ack = 1'b1; fetch_ready = 1'b1;
    repeat (3) tick();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF9;
    tick();
    redirect = 1'b0;
    j = 0;
    for (int c = 0; c < 20 && j < 4; c++) begin
      @(negedge clk);
      if (instr_valid && fetch_ready) begin
        n_cmp++;
        if (instr_pc !== exp_pc[j]) begin
          n_bad++;
          $display("FAIL wrap_pc: got %h expected %h", instr_pc, exp_pc[j]);
        end
        j++;
      end
    end
    n_cmp++;
    if (j != 4) begin
      n_bad++;
      $display("FAIL wrap_count: got %0d expected 4", j);
    end
  endtask

  // Ack into an empty FIFO: same-cycle bypass only in the bypass build.
  task automatic test_bypass();
    do_reset();
    fetch_ready = 1'b1; imem_ack = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h20;
    tick();
    redirect = 1'b0;
    tick();
    imem_ack = 1'b1;
    #1;
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h20 || occupancy !== 3'd0 ||
        instr_valid !== BYP || instr !== (BYP ? 32'h0050_0093 : NOP_W) || instr_pc !== (BYP ? 32'h20 : 32'h0)) begin
      n_bad++;
      $display("FAIL bypass_cycle: got req=%b addr=%h occ=%0d v=%b instr=%h pc=%h expected bypass=%b",
               imem_req, imem_addr, occupancy, instr_valid, instr, instr_pc, BYP);
    end
    tick();
    imem_ack = 1'b0;
    n_cmp++;
    if (occupancy !== (BYP ? 3'd0 : 3'd1) || instr_pc !== (BYP ? 32'h0 : 32'h20)) begin
      n_bad++;
      $display("FAIL bypass_after: got occ=%0d pc=%h expected occ=%0d", occupancy, instr_pc, BYP ? 0 : 1);
    end
    tick();
  endtask

  // Random ack latency, stalls, redirects and the odd reset.
  task automatic test_random();
    int start_pops;
    do_reset();
    start_pops = n_pops;
    for (int c = 0; c < 3000; c++) begin
      tick();
      imem_ack    = ($urandom_range(0, 1) == 1);
      fetch_ready = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : ($urandom & 32'h0000_0FFF);
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end
    end
    redirect = 1'b0;
    n_cmp++;
    if (n_pops - start_pops < 300) begin
      n_bad++;
      $display("FAIL random_progress: got %0d pops expected >= 300", n_pops - start_pops);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_stream();
    test_fill();
    test_redirect_flush();
    test_drop();
    test_redirect_ack_same();
    test_wrap();
    test_bypass();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
